eth_cmd_arbiter: RTL and testbench

Shares the single register-write command port between two command sources: the Ethernet frame parser (source 0) and a secondary local command source (source 1, e.g. UART/debug). Each source delivers one-cycle command pulses (address + 32-bit data). The block buffers each source in its own FIFO, arbitrates round-robin, and issues one command at a time to the register bank over a valid/ready handshake. It sits between the command parsers and the configuration register file.

---
 rtl/eth_cmd_pkg.sv | 17 +
 rtl/eth_cmd_arbiter_fifo.sv | 53 +++++
 rtl/eth_cmd_arbiter.sv | 116 +++++++++++
 tb/tb_eth_cmd_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_cmd_pkg.sv
// Shared types and constants for the register-write command path:
// default field widths, arbiter FSM states and parser framing bytes.
package eth_cmd_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam logic [7:0] FRAME_HDR0    = 8'h55;
    localparam logic [7:0] FRAME_HDR1    = 8'hA5;
    localparam logic [7:0] FRAME_TRAILER = 8'hF0;

endpackage

// File: rtl/eth_cmd_arbiter_fifo.sv
// Synchronous FIFO for one command source; a push into a full FIFO is
// accepted only when the same cycle also pops it.
module cmd_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/eth_cmd_arbiter.sv
// Round-robin merge of the Ethernet parser and local command sources onto
// the single register-bank write port, one command in flight at a time.
module eth_cmd_arbiter
    import eth_cmd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s0_valid,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s1_valid,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_src,
    output logic              ovf0,
    output logic              ovf1,
    input  logic              clr_ovf,
    output logic              busy
);
    localparam int CW = ADDR_W + DATA_W;
    localparam int NW = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              src_q, src_d;
    logic              ovf0_q, ovf0_d, ovf1_q, ovf1_d;

    logic [CW-1:0]     rdata0, rdata1;
    logic              full0, empty0, full1, empty1;
    logic [NW-1:0]     cnt0, cnt1;
    logic              pop0, pop1, win;

    cmd_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .reset_n(reset_n),
        .push_i(s0_valid), .wdata_i({s0_addr, s0_data}),
        .pop_i(pop0), .rdata_o(rdata0),
        .full_o(full0), .empty_o(empty0), .count_o(cnt0)
    );

    cmd_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .reset_n(reset_n),
        .push_i(s1_valid), .wdata_i({s1_addr, s1_data}),
        .pop_i(pop1), .rdata_o(rdata1),
        .full_o(full1), .empty_o(empty1), .count_o(cnt1)
    );

    // With both sources pending, the one not granted last time wins.
    assign win = (!empty0 && !empty1) ? ~last_grant_q : empty0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        src_d        = src_q;
        pop0         = 1'b0;
        pop1         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty0 || !empty1) begin
                    pop0         = ~win;
                    pop1         = win;
                    {addr_d, data_d} = win ? rdata1 : rdata0;
                    src_d        = win;
                    last_grant_d = win;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ovf0_d = (s0_valid && full0 && !pop0) ? 1'b1 : (clr_ovf ? 1'b0 : ovf0_q);
        ovf1_d = (s1_valid && full1 && !pop1) ? 1'b1 : (clr_ovf ? 1'b0 : ovf1_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            data_q       <= '0;
            src_q        <= 1'b0;
            ovf0_q       <= 1'b0;
            ovf1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            src_q        <= src_d;
            ovf0_q       <= ovf0_d;
            ovf1_q       <= ovf1_d;
        end
    end

    assign m_valid = (state_q == ISSUE);
    assign m_addr  = addr_q;
    assign m_data  = data_q;
    assign m_src   = src_q;
    assign ovf0    = ovf0_q;
    assign ovf1    = ovf1_q;
    assign busy    = (cnt0 != '0) || (cnt1 != '0) || m_valid;

endmodule

// File: tb/tb_eth_cmd_arbiter.sv
// Directed and randomized checks of eth_cmd_arbiter against a queue-based
// reference model of the two-source round-robin command merge.
module tb_eth_cmd_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    typedef logic [AW+DW-1:0] cmd_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          s0_valid, s1_valid, m_ready, clr_ovf;
    logic [AW-1:0] s0_addr, s1_addr;
    logic [DW-1:0] s0_data, s1_data;
    logic          m_valid, m_src, ovf0, ovf1, busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    eth_cmd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
        .m_src(m_src), .ovf0(ovf0), .ovf1(ovf1), .clr_ovf(clr_ovf), .busy(busy)
    );

    int n_assert = 0;
    int n_fail = 0;

    // Reference model: per-source queues plus the single presented slot.
    cmd_t mq0[$], mq1[$];
    bit   md_held, md_lg, md_src, md_ovf0, md_ovf1;
    cmd_t md_cmd;
    int   acc_cnt, hs_cnt;
    bit   hs_src[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq0.delete(); mq1.delete();
        md_held = 0; md_lg = 1; md_src = 0; md_cmd = '0;
        md_ovf0 = 0; md_ovf1 = 0;
    endtask

    function automatic bit model_busy();
        return md_held || (mq0.size() > 0) || (mq1.size() > 0);
    endfunction

    task automatic model_step();
        bit p0, p1, d0, d1, hs;
        hs = md_held && m_ready;
        p0 = 0; p1 = 0; d0 = 0; d1 = 0;
        if (!md_held && (mq0.size() > 0 || mq1.size() > 0)) begin
            if (mq0.size() > 0 && mq1.size() > 0) begin
                if (md_lg) p0 = 1; else p1 = 1;
            end else if (mq0.size() > 0) p0 = 1;
            else p1 = 1;
        end
        if (p0) begin md_cmd = mq0.pop_front(); md_src = 0; md_lg = 0; md_held = 1; end
        else if (p1) begin md_cmd = mq1.pop_front(); md_src = 1; md_lg = 1; md_held = 1; end
        else if (hs) md_held = 0;
        if (s0_valid) begin
            if (mq0.size() < DEPTH) begin mq0.push_back({s0_addr, s0_data}); acc_cnt++; end
            else d0 = 1;
        end
        if (s1_valid) begin
            if (mq1.size() < DEPTH) begin mq1.push_back({s1_addr, s1_data}); acc_cnt++; end
            else d1 = 1;
        end
        md_ovf0 = d0 ? 1'b1 : (clr_ovf ? 1'b0 : md_ovf0);
        md_ovf1 = d1 ? 1'b1 : (clr_ovf ? 1'b0 : md_ovf1);
    endtask

    task automatic check_all();
        chk("m_valid", m_valid, md_held);
        chk("m_addr", m_addr, md_cmd[AW+DW-1:DW]);
        chk("m_data", m_data, md_cmd[DW-1:0]);
        chk("m_src", m_src, md_src);
        chk("ovf0", ovf0, md_ovf0);
        chk("ovf1", ovf1, md_ovf1);
        chk("busy", busy, model_busy());
    endtask

    task automatic tick();
        if (reset_n) begin
            if (m_valid && m_ready) begin hs_cnt++; hs_src.push_back(m_src); end
            model_step();
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle_inputs();
        s0_valid = 0; s1_valid = 0; clr_ovf = 0;
        s0_addr = '0; s0_data = '0; s1_addr = '0; s1_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1;
        hs_cnt = 0; hs_src.delete(); acc_cnt = 0;
    endtask

    task automatic pulse(input bit src, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (src) begin s1_valid = 1; s1_addr = a; s1_data = d; end
        else begin s0_valid = 1; s0_addr = a; s0_data = d; end
        tick();
        s0_valid = 0; s1_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_src[4];
        int guard;
        m_ready = 0;
        acc_cnt = 0; hs_cnt = 0;
        do_reset();
        check_all();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);

        // Single command: latency of two cycles, idle right after handshake
        m_ready = 1;
        repeat (7) tick();
        pulse(0, 8'h12, 32'hDEADBEEF);
        chk("lat_n1_valid", m_valid, 0);
        tick();
        chk("lat_n2_valid", m_valid, 1);
        chk("lat_n2_addr", m_addr, 8'h12);
        chk("lat_n2_data", m_data, 32'hDEADBEEF);
        chk("lat_n2_src", m_src, 0);
        tick();
        chk("lat_n3_busy", busy, 0);

        // Simultaneous sources alternate starting from source 0
        do_reset();
        m_ready = 1;
        s0_valid = 1; s0_addr = 8'h01; s0_data = 32'h11111111;
        s1_valid = 1; s1_addr = 8'h02; s1_data = 32'h22222222;
        tick();
        idle_inputs();
        repeat (5) tick();
        s0_valid = 1; s0_addr = 8'h03; s0_data = 32'h33333333;
        s1_valid = 1; s1_addr = 8'h04; s1_data = 32'h44444444;
        tick();
        idle_inputs();
        repeat (5) tick();
        exp_src = '{0, 1, 0, 1};
        chk("rr_count", hs_cnt, 4);
        for (int i = 0; i < 4; i++)
            chk("rr_order", (i < hs_src.size()) ? 64'(hs_src[i]) : 64'hX, exp_src[i]);

        // Backpressure holds the presented command stable
        m_ready = 0;
        hs_cnt = 0;
        pulse(1, 8'h33, 32'hCAFEF00D);
        tick();
        repeat (20) begin
            tick();
            chk("bp_valid", m_valid, 1);
            chk("bp_addr", m_addr, 8'h33);
            chk("bp_data", m_data, 32'hCAFEF00D);
        end
        m_ready = 1;
        tick();
        m_ready = 0;
        repeat (5) tick();
        chk("bp_one_hs", hs_cnt, 1);
        chk("bp_no_dup", m_valid, 0);

        // Overflow: six pulses into a blocked source 1
        do_reset();
        m_ready = 0;
        for (int i = 0; i < 6; i++) pulse(1, 8'(8'h40 + i), 32'h1000 + i);
        chk("ovf1_set", ovf1, 1);
        chk("ovf0_clear", ovf0, 0);
        m_ready = 1;
        repeat (12) tick();
        chk("ovf_issued", hs_cnt, 5);
        chk("ovf_accepted", acc_cnt, 5);
        clr_ovf = 1;
        tick();
        clr_ovf = 0;
        chk("ovf1_cleared", ovf1, 0);
        m_ready = 0;
        for (int i = 0; i < 5; i++) pulse(1, 8'(8'h60 + i), 32'h2000 + i);
        chk("ovf1_before_drop", ovf1, 0);
        clr_ovf = 1;
        pulse(1, 8'h6F, 32'h20FF);
        clr_ovf = 0;
        chk("ovf1_set_wins", ovf1, 1);
        clr_ovf = 1;
        tick();
        clr_ovf = 0;
        m_ready = 1;
        repeat (12) tick();
        chk("ovf_drain_busy", busy, 0);

        // Asynchronous reset in the middle of activity
        m_ready = 0;
        for (int i = 0; i < 3; i++) pulse(0, 8'(8'h50 + i), 32'h5000 + i);
        chk("mid_valid", m_valid, 1);
        #2;
        reset_n = 0;
        model_reset();
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_addr", m_addr, 0);
        chk("arst_data", m_data, 0);
        chk("arst_src", m_src, 0);
        chk("arst_ovf", {ovf0, ovf1}, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        reset_n = 1;
        hs_cnt = 0;
        m_ready = 1;
        repeat (10) tick();
        chk("arst_no_issue", hs_cnt, 0);
        pulse(1, 8'h77, 32'h77777777);
        repeat (4) tick();
        chk("arst_new_issue", hs_cnt, 1);

        // Random stress against the reference model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            s0_valid = ($urandom_range(0, 99) < 35);
            s0_addr  = AW'($urandom);
            s0_data  = $urandom;
            s1_valid = ($urandom_range(0, 99) < 35);
            s1_addr  = AW'($urandom);
            s1_data  = $urandom;
            m_ready  = ($urandom_range(0, 99) < 50);
            clr_ovf  = ($urandom_range(0, 99) < 3);
            tick();
        end
        idle_inputs();
        m_ready = 1;
        guard = 0;
        while (model_busy() && guard < 100) begin
            tick();
            guard++;
        end
        chk("drain_in_time", guard < 100, 1);
        tick();
        chk("issued_eq_accepted", hs_cnt, acc_cnt);
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
